// File: rtl/morra_host.sv
// morra_host: match controller on the driving side of the MorraCinese core.
// Collects player moves, plays rounds on the core and keeps the score.
module morra_host #(
  parameter int TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] p1_move,
  input  logic       p1_valid,
  output logic       p1_ready,
  input  logic [1:0] p2_move,
  input  logic       p2_valid,
  output logic       p2_ready,
  output logic [1:0] PRIMO,
  output logic [1:0] SECONDO,
  output logic       INIZIO,
  input  logic [1:0] MANCHE,
  input  logic [1:0] PARTITA,
  output logic       res_valid,
  output logic [1:0] res_manche,
  output logic [1:0] res_partita,
  output logic [4:0] res_round,
  output logic [4:0] wins1,
  output logic [4:0] wins2,
  output logic       busy,
  output logic       done,
  output logic       aborted
);

  typedef enum logic [2:0] {
    IDLE, INIT, COLLECT, PLAY, CAPTURE, DONE
  } state_t;

  state_t      state, state_n;
  logic [1:0]  m1, m2;
  logic [31:0] wd;
  logic        take1, take2;
  logic        full1_n, full2_n;
  logic        both_n, expire, start_match;

  // A latch is full exactly when it holds a non-zero move.
  assign take1 = p1_valid && p1_ready && (p1_move != 2'b00);
  assign take2 = p2_valid && p2_ready && (p2_move != 2'b00);
  assign full1_n = (m1 != 2'b00) || take1;
  assign full2_n = (m2 != 2'b00) || take2;
  assign both_n = full1_n && full2_n;
  assign expire = (TIMEOUT != 0) && !both_n &&
                  (wd == 32'(TIMEOUT - 1));
  assign start_match = start &&
                       (state == IDLE || state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE, DONE: if (start) state_n = INIT;
      INIT:       state_n = COLLECT;
      COLLECT: begin
        if (both_n)      state_n = PLAY;
        else if (expire) state_n = IDLE;
      end
      PLAY:    state_n = CAPTURE;
      CAPTURE: state_n = (PARTITA != 2'b00) ? DONE : COLLECT;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    INIZIO   = (state == INIT);
    PRIMO    = (state == PLAY) ? m1 : 2'b00;
    SECONDO  = (state == PLAY) ? m2 : 2'b00;
    p1_ready = (state == COLLECT) && (m1 == 2'b00);
    p2_ready = (state == COLLECT) && (m2 == 2'b00);
    busy     = (state == INIT) || (state == COLLECT) ||
               (state == PLAY) || (state == CAPTURE);
    done     = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m1          <= 2'b00;
      m2          <= 2'b00;
      wd          <= '0;
      res_valid   <= 1'b0;
      res_manche  <= 2'b00;
      res_partita <= 2'b00;
      res_round   <= '0;
      wins1       <= '0;
      wins2       <= '0;
      aborted     <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      aborted   <= 1'b0;
      wd        <= (state == COLLECT) ? wd + 32'd1 : '0;
      unique case (1'b1)
        start_match: begin
          m1        <= 2'b00;
          m2        <= 2'b00;
          res_round <= '0;
          wins1     <= '0;
          wins2     <= '0;
        end
        state == COLLECT: begin
          if (expire) begin
            m1      <= 2'b00;
            m2      <= 2'b00;
            aborted <= 1'b1;
          end else begin
            if (take1) m1 <= p1_move;
            if (take2) m2 <= p2_move;
          end
        end
        state == PLAY: begin
          m1 <= 2'b00;
          m2 <= 2'b00;
        end
        state == CAPTURE: begin
          res_valid   <= 1'b1;
          res_manche  <= MANCHE;
          res_partita <= PARTITA;
          if (res_round != 5'd31)
            res_round <= res_round + 5'd1;
          if (MANCHE == 2'b01 && wins1 != 5'd31)
            wins1 <= wins1 + 5'd1;
          if (MANCHE == 2'b10 && wins2 != 5'd31)
            wins2 <= wins2 + 5'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/morra_host.md
# morra_host

Match controller on the driving side of the `MorraCinese` game core. It collects one move per player through independent valid/ready handshakes and opens each match with a one-cycle `INIZIO` pulse. It presents each round's moves to the core for exactly one cycle, captures `MANCHE`/`PARTITA`, and reports per-round results and running scores. It replaces the bench-style stimulus driver with synthesizable logic, so two external player sources can play full matches against the core.

## Interface
Parameters:
- `TIMEOUT`, default 1000: cycles allowed in COLLECT before a round is aborted. 0 disables the watchdog.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: rising-edge clock shared with the game core.
- `rst` in 1: asynchronous active-high reset.
- `start` in 1: request a new match. Honoured only in IDLE or DONE.
- `p1_move` in 2: player 1 move. 01 = rock, 10 = paper, 11 = scissors, 00 = no move.
- `p1_valid` in 1: `p1_move` is offered.
- `p1_ready` out 1: host accepts a player 1 move.
- `p2_move`, `p2_valid`, `p2_ready`: same as the player 1 ports, for player 2.
- `PRIMO` out 2, `SECONDO` out 2, `INIZIO` out 1: drive the core's inputs of the same names.
- `MANCHE` in 2: core round result. 00 = invalid, 01 = P1 wins, 10 = P2 wins, 11 = draw.
- `PARTITA` in 2: core match result. 00 = ongoing, 01 = P1 wins, 10 = P2 wins, 11 = draw.
- `res_valid` out 1: one-cycle pulse; `res_*` outputs are valid in that cycle.
- `res_manche` out 2, `res_partita` out 2: captured copies of `MANCHE` and `PARTITA`.
- `res_round` out 5: number of rounds played, including this one.
- `wins1` out 5, `wins2` out 5: running round wins per player.
- `busy` out 1: high in INIT, COLLECT, PLAY and CAPTURE.
- `done` out 1: high while in DONE.
- `aborted` out 1: one-cycle pulse when the watchdog fires.

## Operation
States: IDLE, INIT, COLLECT, PLAY, CAPTURE, DONE.

- **IDLE / DONE**
  - `start` → INIT.
  - On entering INIT: `wins1`, `wins2`, `res_round` and both move latches clear.
- **INIT** (one cycle)
  - `INIZIO`=1, `PRIMO`=`SECONDO`=00.
  - → COLLECT.
- **COLLECT**
  - `pN_ready` = 1 while that player's latch is empty.
  - A transfer happens when `pN_valid` & `pN_ready`.
  - A transferred 00 is discarded: latch stays empty, ready stays high.
  - Latches fill independently and in any order, including in the same cycle.
  - Once a latch is full, its ready drops and further valids are ignored.
  - Both latches full → PLAY.
- **PLAY** (one cycle)
  - `PRIMO`/`SECONDO` = latched moves.
  - Both latches clear.
  - → CAPTURE.
- **CAPTURE** (one cycle)
  - `MANCHE`/`PARTITA` are sampled at the closing edge into `res_manche`/`res_partita`.
  - `res_round` increments, saturating at 31.
  - `MANCHE`=01 → `wins1`+1; `MANCHE`=10 → `wins2`+1. Both saturate at 31.
  - `PARTITA`≠00 → DONE, otherwise → COLLECT.
- **Outside PLAY and INIT**: `PRIMO`=`SECONDO`=00, `INIZIO`=0. The core treats a 00 move as an invalid manche with no score change.
- **`start` while busy**: ignored.
- **Watchdog**
  - Counter clears on every entry to COLLECT.
  - Reaching `TIMEOUT` in COLLECT with a latch still empty → `aborted` pulse, latches clear, → IDLE.
  - `wins*` and `res_*` are retained after an abort.
- **`rst`** (asynchronous, any state, including mid-PLAY)
  - State → IDLE.
  - All outputs 0: `PRIMO`/`SECONDO`=00, `INIZIO`=0, readies 0, `res_*`/`wins*`=0, `busy`/`done`/`aborted`=0.

## Timing
- `start` sampled at edge 0 → INIT in cycle 1 (`INIZIO`=1) → COLLECT in cycle 2 (readies high).
- Last move transferred at edge k:
  - PLAY in cycle k+1.
  - Core samples the moves at edge k+2.
  - CAPTURE in cycle k+2.
  - `res_valid`=1 in cycle k+3, with updated `wins*`/`res_*` and next state COLLECT or DONE.
- Minimum round period: 3 cycles (ready is low in PLAY and CAPTURE).
- `done` rises in cycle k+3 together with the final `res_valid`.
- `res_*` hold their value until the next capture.

## Test plan
- **Reset values:** assert `rst` mid-run → all outputs 0 immediately (asynchronous); release → IDLE, readies stay 0.
- **Match start:** `start`=1 for one cycle → `INIZIO`=1 in exactly one cycle with `PRIMO`/`SECONDO`=00; readies high the next cycle.
- **Single round:** P1=01, P2=11 in the same cycle (edge k), core model returns `MANCHE`=01, `PARTITA`=00 → `PRIMO`=01, `SECONDO`=11 only in cycle k+1; in cycle k+3 `res_valid`=1, `res_manche`=01, `res_round`=1, `wins1`=1, `wins2`=0, readies high.
- **Skewed and invalid moves:** P2 offers 00 then 10; P1 offers 10 three cycles later → the 00 is dropped with `p2_ready` still high; PLAY starts only after P1's transfer and drives `SECONDO`=10.
- **Match end:** core returns `PARTITA`=10 → `done`=1, readies 0, later valids ignored; next `start` clears `wins*` and `res_round` to 0.
- **Watchdog:** with `TIMEOUT`=8, only P1 moves → `aborted` pulses 8 cycles after entering COLLECT, state IDLE, `busy`=0.
